// File: rtl/parking_lot_if.sv
// parking_lot_if: sensor inputs and occupancy/event outputs of the parking lot counter.
interface parking_lot_if #(
    parameter int CAPACITY = 255
);
    localparam int COUNT_W = $clog2(CAPACITY + 1);
    logic               sensor_a_i;
    logic               sensor_b_i;
    logic               car_enter_o;
    logic               car_exit_o;
    logic [COUNT_W-1:0] count_o;
    logic               full_o;
    logic               empty_o;
    logic               error_o;
    modport master (
        output sensor_a_i, sensor_b_i,
        input  car_enter_o, car_exit_o, count_o, full_o, empty_o, error_o
    );
    modport slave (
        input  sensor_a_i, sensor_b_i,
        output car_enter_o, car_exit_o, count_o, full_o, empty_o, error_o
    );
endinterface

// File: rtl/parking_lot_counter.sv
// parking_lot_counter: decodes A/B beam sequences into entry/exit events and keeps a saturating occupancy count.
module parking_lot_counter #(
    parameter  int CAPACITY = 255,
    localparam int COUNT_W  = $clog2(CAPACITY + 1)
) (
    input logic         clk_i,
    input logic         rst_i,
    parking_lot_if.slave bus
);
    typedef enum logic [2:0] {IDLE, EN_A, EN_AB, EN_B, EX_B, EX_AB, EX_A, FAULT} state_t;
    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               enter_q, enter_d, exit_q, exit_d, err_q, err_d;
    logic [1:0]         ab;
    assign ab = {bus.sensor_a_i, bus.sensor_b_i};
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ab == 2'b10 ? EN_A  : ab == 2'b01 ? EX_B  : ab == 2'b11 ? FAULT : IDLE;
            EN_A:    state_d = ab == 2'b11 ? EN_AB : ab == 2'b00 ? IDLE  : ab == 2'b01 ? FAULT : EN_A;
            EN_AB:   state_d = ab == 2'b01 ? EN_B  : ab == 2'b10 ? EN_A  : ab == 2'b00 ? FAULT : EN_AB;
            EN_B:    state_d = ab == 2'b11 ? EN_AB : ab == 2'b00 ? IDLE  : ab == 2'b10 ? FAULT : EN_B;
            EX_B:    state_d = ab == 2'b11 ? EX_AB : ab == 2'b00 ? IDLE  : ab == 2'b10 ? FAULT : EX_B;
            EX_AB:   state_d = ab == 2'b10 ? EX_A  : ab == 2'b01 ? EX_B  : ab == 2'b00 ? FAULT : EX_AB;
            EX_A:    state_d = ab == 2'b11 ? EX_AB : ab == 2'b00 ? IDLE  : ab == 2'b01 ? FAULT : EX_A;
            FAULT:   state_d = ab == 2'b00 ? IDLE  : FAULT;
            default: state_d = IDLE;
        endcase
        enter_d = state_q == EN_B && ab == 2'b00;
        exit_d  = state_q == EX_A && ab == 2'b00;
        // error pulses only on the transition into FAULT, not while parked there
        err_d   = state_d == FAULT && state_q != FAULT;
        count_d = enter_d && count_q != COUNT_W'(CAPACITY) ? count_q + 1'b1 :
                  exit_d && count_q != '0                  ? count_q - 1'b1 : count_q;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
            err_q   <= err_d;
        end
    end
    assign bus.car_enter_o = enter_q;
    assign bus.car_exit_o  = exit_q;
    assign bus.error_o     = err_q;
    assign bus.count_o     = count_q;
    assign bus.full_o      = count_q == COUNT_W'(CAPACITY);
    assign bus.empty_o     = count_q == '0;
endmodule

// File: tb/tb_parking_lot_counter.sv
// tb_parking_lot_counter: directed sequences; expected event pulses are queued when the completing
// sample is driven and matched (kind, count, cycle) when the DUT pulses.
module tb_parking_lot_counter;
    localparam int CAP = 3;
    localparam logic [2:0] EV_ENTER = 3'b100, EV_EXIT = 3'b010, EV_ERR = 3'b001;
    typedef struct {
        logic [2:0] kind;
        int         cnt;
        int         cyc;
    } ev_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   mcnt = 0;
    ev_t  q[$];
    parking_lot_if #(.CAPACITY(CAP)) bus ();
    parking_lot_counter #(.CAPACITY(CAP)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic step(input logic [1:0] ab, input int n);
        {bus.sensor_a_i, bus.sensor_b_i} = ab;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic expect_ev(input logic [2:0] kind);
        ev_t e;
        if (kind == EV_ENTER && mcnt < CAP) mcnt++;
        if (kind == EV_EXIT && mcnt > 0) mcnt--;
        e.kind = kind;
        e.cnt  = mcnt;
        e.cyc  = cyc + 1;
        q.push_back(e);
    endtask
    task automatic entry();
        step(2'b10, 3);
        step(2'b11, 3);
        step(2'b01, 3);
        expect_ev(EV_ENTER);
        step(2'b00, 3);
    endtask
    task automatic leave();
        step(2'b01, 3);
        step(2'b11, 3);
        step(2'b10, 3);
        expect_ev(EV_EXIT);
        step(2'b00, 3);
    endtask
    always @(negedge clk) begin
        logic [2:0] p;
        ev_t e;
        p = {bus.car_enter_o, bus.car_exit_o, bus.error_o};
        if (!rst && p != 3'b000) begin
            if (q.size() == 0) chk("unexpected_pulse", int'(p), 0);
            else begin
                e = q.pop_front();
                chk("pulse_kind", int'(p), int'(e.kind));
                chk("pulse_count", int'(bus.count_o), e.cnt);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end
    initial begin
        {bus.sensor_a_i, bus.sensor_b_i} = 2'b00;
        step(2'b00, 3);
        chk("rst_count", int'(bus.count_o), 0);
        chk("rst_empty", int'(bus.empty_o), 1);
        chk("rst_full", int'(bus.full_o), 0);
        chk("rst_pulses", int'({bus.car_enter_o, bus.car_exit_o, bus.error_o}), 0);
        #4 rst = 1'b0;
        step(2'b00, 2);
        entry();
        chk("entry_count", int'(bus.count_o), 1);
        chk("entry_empty", int'(bus.empty_o), 0);
        leave();
        chk("exit_count", int'(bus.count_o), 0);
        chk("exit_empty", int'(bus.empty_o), 1);
        step(2'b10, 2);
        step(2'b11, 2);
        step(2'b10, 2);
        step(2'b00, 3);
        chk("abort_count", int'(bus.count_o), 0);
        step(2'b10, 2);
        step(2'b11, 2);
        step(2'b01, 2);
        step(2'b11, 2);
        step(2'b01, 2);
        expect_ev(EV_ENTER);
        step(2'b00, 3);
        chk("reversal_count", int'(bus.count_o), 1);
        expect_ev(EV_ERR);
        step(2'b11, 6);
        step(2'b00, 2);
        chk("fault_count", int'(bus.count_o), 1);
        entry();
        chk("post_fault_count", int'(bus.count_o), 2);
        step(2'b10, 2);
        step(2'b11, 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", int'(bus.count_o), 0);
        chk("async_rst_empty", int'(bus.empty_o), 1);
        mcnt = 0;
        {bus.sensor_a_i, bus.sensor_b_i} = 2'b00;
        step(2'b00, 2);
        #2 rst = 1'b0;
        step(2'b00, 3);
        chk("post_rst_count", int'(bus.count_o), 0);
        for (int i = 0; i < 4; i++) entry();
        chk("sat_count", int'(bus.count_o), CAP);
        chk("sat_full", int'(bus.full_o), 1);
        for (int i = 0; i < 5; i++) begin
            leave();
            chk("drain_count", int'(bus.count_o), (i < 3) ? CAP - 1 - i : 0);
        end
        chk("drain_empty", int'(bus.empty_o), 1);
        chk("drain_full", int'(bus.full_o), 0);
        step(2'b00, 2);
        chk("missing_pulses", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/parking_lot_counter.md
Name: parking_lot_counter

Overview:
- Consumes the two debounced sensor levels (sensor A outside, sensor B inside) produced by the front-end debouncers.
- Decodes the A/B occlusion sequence into car-entered and car-exited events.
- Maintains a saturating occupancy count with full/empty flags, feeding the display and gate logic.
- Rejects aborted passes (car backs out) and flags illegal sensor transitions.

Parameters:
- CAPACITY, 255, maximum occupancy; count saturates here.
- COUNT_W, $clog2(CAPACITY+1), width of count_o (derived; do not override).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset, asynchronous, active-high.
- sensor_a_i  input  1  debounced outer sensor, 1 = beam blocked.
- sensor_b_i  input  1  debounced inner sensor, 1 = beam blocked.
- car_enter_o  output  1  one-cycle pulse per completed entry.
- car_exit_o  output  1  one-cycle pulse per completed exit.
- count_o  output  COUNT_W  current occupancy.
- full_o  output  1  count_o == CAPACITY.
- empty_o  output  1  count_o == 0.
- error_o  output  1  one-cycle pulse on illegal sensor transition.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous, active-high.
- Inputs are synchronous to clk_i (debouncers share the clock). No internal synchronizers.
- Notation: "ab" = {sensor_a_i, sensor_b_i}, sampled at each rising edge.
- Reset values:
  - state = IDLE, count = 0.
  - car_enter_o = car_exit_o = error_o = 0.
  - empty_o = 1, full_o = 0.
- Reset mid-sequence discards all progress; no event pulse is produced.
- All outputs are registered. full_o and empty_o are decoded from the count register and track it in the same cycle.
- FSM states: IDLE, EN_A, EN_AB, EN_B, EX_B, EX_AB, EX_A, FAULT.
  - IDLE: 00 stay; 10 -> EN_A; 01 -> EX_B; 11 -> FAULT.
  - EN_A: 10 stay; 11 -> EN_AB; 00 -> IDLE (aborted, no event); 01 -> FAULT.
  - EN_AB: 11 stay; 01 -> EN_B; 10 -> EN_A (reversal); 00 -> FAULT.
  - EN_B: 01 stay; 11 -> EN_AB (reversal); 00 -> IDLE with entry event; 10 -> FAULT.
  - EX_B: 01 stay; 11 -> EX_AB; 00 -> IDLE (aborted); 10 -> FAULT.
  - EX_AB: 11 stay; 10 -> EX_A; 01 -> EX_B (reversal); 00 -> FAULT.
  - EX_A: 10 stay; 11 -> EX_AB (reversal); 00 -> IDLE with exit event; 01 -> FAULT.
  - FAULT: any ab != 00 stay; 00 -> IDLE. No events are decoded while in FAULT.
- Illegal transition: both bits change in one sample, or a skipped phase. On entry to FAULT, error_o is high for exactly one cycle. It does not re-pulse while the FSM remains in FAULT.
- Event timing:
  - The edge that samples the completing 00 updates the state, the pulse register and count together.
  - car_enter_o / car_exit_o are high for exactly the following cycle.
  - count_o shows the new value from that same cycle.
  - Latency: one clock from the final 00 sample to pulse.
- Count arithmetic:
  - Entry: count+1 when count < CAPACITY. At CAPACITY, count holds; car_enter_o still pulses.
  - Exit: count-1 when count > 0. At 0, count holds (no wrap to all-ones); car_exit_o still pulses.
  - Entry and exit cannot complete in the same cycle (single FSM), so no simultaneous-update case exists.
- Back-to-back cars: a new 10 or 01 sampled on the cycle after the return to IDLE starts a new sequence normally. Zero dead cycles.

Test Plan:
- Entry: from reset, drive ab 00,10,11,01,00 holding each 3 cycles -> one car_enter_o pulse one cycle after the final 00; count_o=1; empty_o 1->0.
- Exit: count=1; drive ab 00,01,11,10,00 -> one car_exit_o pulse; count_o=0; empty_o=1; error_o stays 0.
- Abort/reversal: ab 10,11,10,00 -> no pulses, count unchanged. ab 10,11,01,11,01,00 -> exactly one entry pulse.
- Illegal: in IDLE drive 11 -> error_o high 1 cycle. Hold 11 for 5 cycles -> no further error. Then 00, then a valid entry -> count +1.
- Saturation: CAPACITY=3. Perform 4 entries -> count_o=3, full_o=1, 4 enter pulses. Perform 5 exits -> count_o=0 after the 3rd exit, holds 0 for the remaining 2, 5 exit pulses.
- Async reset: assert rst_i mid-EN_AB, between clock edges, with count=2 -> count_o=0, empty_o=1 immediately without a clock edge. After release, ab=00 -> IDLE with no pulse.
